// File: rtl/streebog_msg_feeder_if.sv
// ============================================================================
// Module      : streebog_msg_feeder_if
// Description : Bundle of the word-input, session, block, result and digest
//               handshakes around the Streebog message feeder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface streebog_msg_feeder_if #(
  parameter int DATA_WIDTH = 512,
  parameter int WORD_WIDTH = 64
);
  localparam int LEN_W = $clog2(DATA_WIDTH) + 1;

  logic                  start_i;
  logic                  hash_len_i;
  logic                  in_valid_i;
  logic                  in_ready_o;
  logic [WORD_WIDTH-1:0] in_data_i;
  logic                  in_last_i;
  logic [3:0]            in_bytes_i;
  logic                  fsm_start_req_o;
  logic                  fsm_start_ack_i;
  logic                  mes_valid_o;
  logic                  mes_ready_i;
  logic [DATA_WIDTH-1:0] message_o;
  logic                  mes_last_o;
  logic [LEN_W-1:0]      mes_last_len_o;
  logic                  hash_len_o;
  logic [DATA_WIDTH-1:0] hash_i;
  logic                  hash_valid_i;
  logic                  hash_ready_o;
  logic [DATA_WIDTH-1:0] digest_o;
  logic                  digest_valid_o;
  logic                  digest_ready_i;
  logic                  busy_o;

  // The feeder itself.
  modport master (
    input  start_i, hash_len_i, in_valid_i, in_data_i, in_last_i, in_bytes_i,
           fsm_start_ack_i, mes_ready_i, hash_i, hash_valid_i, digest_ready_i,
    output in_ready_o, fsm_start_req_o, mes_valid_o, message_o, mes_last_o,
           mes_last_len_o, hash_len_o, hash_ready_o, digest_o, digest_valid_o,
           busy_o
  );

  // The surrounding environment (word source, hash core, digest consumer).
  modport slave (
    output start_i, hash_len_i, in_valid_i, in_data_i, in_last_i, in_bytes_i,
           fsm_start_ack_i, mes_ready_i, hash_i, hash_valid_i, digest_ready_i,
    input  in_ready_o, fsm_start_req_o, mes_valid_o, message_o, mes_last_o,
           mes_last_len_o, hash_len_o, hash_ready_o, digest_o, digest_valid_o,
           busy_o
  );
endinterface

`default_nettype wire

// File: rtl/streebog_msg_feeder.sv
// ============================================================================
// Module      : streebog_msg_feeder
// Description : Packs 64-bit message words into padded 512-bit blocks for a
//               Streebog hash core, runs the session handshake with the core
//               and forwards the (optionally truncated) digest.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module streebog_msg_feeder #(
  parameter int DATA_WIDTH = 512,
  parameter int WORD_WIDTH = 64
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  streebog_msg_feeder_if.master  bus
);
  localparam int WORDS = DATA_WIDTH / WORD_WIDTH;
  localparam int IDX_W = $clog2(WORDS);
  localparam int BYTES = WORD_WIDTH / 8;
  localparam int LEN_W = $clog2(DATA_WIDTH) + 1;
  localparam int HALF  = DATA_WIDTH / 2;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FILL   = 3'd1,
    SEND   = 3'd2,
    HASH   = 3'd3,
    REL_HI = 3'd4,
    REL_LO = 3'd5,
    DONE   = 3'd6
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] buf_q, buf_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  last_q, last_d;
  logic [LEN_W-1:0]      len_q, len_d;
  logic                  hlen_q, hlen_d;
  logic                  req_q, req_d;
  logic [DATA_WIDTH-1:0] digest_q, digest_d;

  logic [3:0]            bytes_eff;
  logic [WORD_WIDTH-1:0] word_masked;
  logic [LEN_W-1:0]      len_calc;

  // Final-word helpers: clamp the byte count, zero unused bytes, compute length.
  always_comb begin
    bytes_eff   = (bus.in_bytes_i > 4'(BYTES)) ? 4'(BYTES) : bus.in_bytes_i;
    word_masked = '0;
    for (int k = 0; k < BYTES; k++) begin
      if (k < int'(bytes_eff)) word_masked[8*k +: 8] = bus.in_data_i[8*k +: 8];
    end
    len_calc = LEN_W'(idx_q) * LEN_W'(WORD_WIDTH) + LEN_W'(bytes_eff) * LEN_W'(8);
  end

  // Next-state and datapath updates for the session FSM.
  always_comb begin
    state_d  = state_q;
    buf_d    = buf_q;
    idx_d    = idx_q;
    last_d   = last_q;
    len_d    = len_q;
    hlen_d   = hlen_q;
    req_d    = req_q;
    digest_d = digest_q;
    case (state_q)
      IDLE: begin
        // A start while the core still acks the previous session is dropped.
        if (bus.start_i && !bus.fsm_start_ack_i) begin
          hlen_d  = bus.hash_len_i;
          req_d   = 1'b1;
          buf_d   = '0;
          idx_d   = '0;
          last_d  = 1'b0;
          len_d   = '0;
          state_d = FILL;
        end
      end
      FILL: begin
        if (bus.in_valid_i) begin
          if (bus.in_last_i) begin
            // Higher words are already zero, so only the pad bit remains.
            buf_d[int'(idx_q)*WORD_WIDTH +: WORD_WIDTH] = word_masked;
            if (len_calc < LEN_W'(DATA_WIDTH)) buf_d[len_calc[LEN_W-2:0]] = 1'b1;
            last_d  = 1'b1;
            len_d   = len_calc;
            state_d = SEND;
          end else begin
            buf_d[int'(idx_q)*WORD_WIDTH +: WORD_WIDTH] = bus.in_data_i;
            if (idx_q == IDX_W'(WORDS - 1)) begin
              last_d  = 1'b0;
              len_d   = '0;
              state_d = SEND;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end
        end
      end
      SEND: begin
        if (bus.mes_ready_i) begin
          if (last_q) begin
            state_d = HASH;
          end else begin
            buf_d   = '0;
            idx_d   = '0;
            state_d = FILL;
          end
        end
      end
      HASH: begin
        if (bus.hash_valid_i) begin
          // A 256-bit digest lives in the upper half of the core result.
          digest_d = hlen_q ? bus.hash_i
                            : {{HALF{1'b0}}, bus.hash_i[DATA_WIDTH-1:HALF]};
          state_d  = REL_HI;
        end
      end
      REL_HI: begin
        if (bus.fsm_start_ack_i) begin
          req_d   = 1'b0;
          state_d = REL_LO;
        end
      end
      REL_LO: begin
        if (!bus.fsm_start_ack_i) state_d = DONE;
      end
      DONE: begin
        if (bus.digest_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset clears everything, even mid-message.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q  <= IDLE;
      buf_q    <= '0;
      idx_q    <= '0;
      last_q   <= 1'b0;
      len_q    <= '0;
      hlen_q   <= 1'b0;
      req_q    <= 1'b0;
      digest_q <= '0;
    end else begin
      state_q  <= state_d;
      buf_q    <= buf_d;
      idx_q    <= idx_d;
      last_q   <= last_d;
      len_q    <= len_d;
      hlen_q   <= hlen_d;
      req_q    <= req_d;
      digest_q <= digest_d;
    end
  end

  assign bus.in_ready_o      = (state_q == FILL);
  assign bus.mes_valid_o     = (state_q == SEND);
  assign bus.message_o       = buf_q;
  assign bus.mes_last_o      = last_q;
  assign bus.mes_last_len_o  = len_q;
  assign bus.hash_len_o      = hlen_q;
  assign bus.hash_ready_o    = (state_q == HASH);
  assign bus.digest_o        = digest_q;
  assign bus.digest_valid_o  = (state_q == DONE);
  assign bus.busy_o          = (state_q != IDLE);
  assign bus.fsm_start_req_o = req_q;

endmodule

`default_nettype wire

// File: tb/tb_streebog_msg_feeder.sv
// ============================================================================
// Module      : tb_streebog_msg_feeder
// Description : Directed self-checking bench for streebog_msg_feeder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_streebog_msg_feeder;
  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   vectors     = 0;
  int   miscompares = 0;

  streebog_msg_feeder_if #(.DATA_WIDTH(512), .WORD_WIDTH(64)) bus ();

  streebog_msg_feeder #(.DATA_WIDTH(512), .WORD_WIDTH(64)) dut (
    .clk_i  (clk),
    .rstn_i (rstn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] wd(input int i);
    return {16'hF00D, 16'(i), 32'h1000_0000 + 32'(i)};
  endfunction

  task automatic start_msg(input logic hl);
    bus.hash_len_i = hl;
    bus.start_i    = 1'b1;
    step();
    bus.start_i    = 1'b0;
    chk("start busy", bus.busy_o, 1'b1);
    chk("start req", bus.fsm_start_req_o, 1'b1);
  endtask

  task automatic put_word(input logic [63:0] d, input logic last, input logic [3:0] nb);
    int n = 0;
    bus.in_valid_i = 1'b1;
    bus.in_data_i  = d;
    bus.in_last_i  = last;
    bus.in_bytes_i = nb;
    while (bus.in_ready_o !== 1'b1 && n < 100) begin step(); n++; end
    chk("in_ready wait", n < 100, 1'b1);
    step();
    bus.in_valid_i = 1'b0;
    bus.in_last_i  = 1'b0;
  endtask

  task automatic take_block(input string tag, input logic [511:0] m,
                            input logic last, input logic [9:0] len);
    int n = 0;
    while (bus.mes_valid_o !== 1'b1 && n < 100) begin step(); n++; end
    chk({tag, " valid wait"}, n < 100, 1'b1);
    chk({tag, " message"}, bus.message_o, m);
    chk({tag, " last"}, bus.mes_last_o, last);
    chk({tag, " len"}, bus.mes_last_len_o, len);
    bus.mes_ready_i = 1'b1;
    step();
    bus.mes_ready_i = 1'b0;
  endtask

  task automatic finish(input string tag, input logic [511:0] h, input logic hl);
    int n = 0;
    logic [511:0] exp_dig;
    exp_dig = hl ? h : {256'b0, h[511:256]};
    while (bus.hash_ready_o !== 1'b1 && n < 100) begin step(); n++; end
    chk({tag, " hash_ready wait"}, n < 100, 1'b1);
    chk({tag, " hash_len_o"}, bus.hash_len_o, hl);
    bus.hash_i       = h;
    bus.hash_valid_i = 1'b1;
    step();
    bus.hash_valid_i    = 1'b0;
    bus.fsm_start_ack_i = 1'b1;
    n = 0;
    while (bus.fsm_start_req_o !== 1'b0 && n < 100) begin step(); n++; end
    chk({tag, " req fall wait"}, n < 100, 1'b1);
    bus.fsm_start_ack_i = 1'b0;
    n = 0;
    while (bus.digest_valid_o !== 1'b1 && n < 100) begin step(); n++; end
    chk({tag, " digest_valid wait"}, n < 100, 1'b1);
    chk({tag, " digest"}, bus.digest_o, exp_dig);
    bus.digest_ready_i = 1'b1;
    step();
    bus.digest_ready_i = 1'b0;
    chk({tag, " idle"}, bus.busy_o, 1'b0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " busy"}, bus.busy_o, 1'b0);
    chk({tag, " in_ready"}, bus.in_ready_o, 1'b0);
    chk({tag, " req"}, bus.fsm_start_req_o, 1'b0);
    chk({tag, " mes_valid"}, bus.mes_valid_o, 1'b0);
    chk({tag, " message"}, bus.message_o, 512'b0);
    chk({tag, " mes_last"}, bus.mes_last_o, 1'b0);
    chk({tag, " len"}, bus.mes_last_len_o, 10'd0);
    chk({tag, " hash_len_o"}, bus.hash_len_o, 1'b0);
    chk({tag, " hash_ready"}, bus.hash_ready_o, 1'b0);
    chk({tag, " digest"}, bus.digest_o, 512'b0);
    chk({tag, " digest_valid"}, bus.digest_valid_o, 1'b0);
  endtask

  initial begin
    logic [511:0] h1, h2, exp_m;
    h1 = {{4{64'h1111_2222_3333_4444}}, {4{64'h5555_6666_7777_8888}}};
    h2 = {{4{64'h9999_AAAA_BBBB_CCCC}}, {4{64'hDDDD_EEEE_0101_2323}}};

    bus.start_i = 1'b0;        bus.hash_len_i = 1'b0;
    bus.in_valid_i = 1'b0;     bus.in_data_i = '0;
    bus.in_last_i = 1'b0;      bus.in_bytes_i = '0;
    bus.fsm_start_ack_i = 1'b0; bus.mes_ready_i = 1'b0;
    bus.hash_i = '0;           bus.hash_valid_i = 1'b0;
    bus.digest_ready_i = 1'b0;

    // Reset state
    repeat (3) step();
    chk_all_zero("reset");
    rstn = 1'b1;
    step();

    // Empty message, 256-bit mode, with an explicit session handshake walk
    start_msg(1'b0);
    chk("t1 in_ready", bus.in_ready_o, 1'b1);
    put_word(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 4'd0);
    chk("t1 mes_valid next cycle", bus.mes_valid_o, 1'b1);
    chk("t1 in_ready in send", bus.in_ready_o, 1'b0);
    take_block("t1", 512'h1, 1'b1, 10'd0);
    chk("t1 hash_ready", bus.hash_ready_o, 1'b1);
    bus.hash_i = h1;
    bus.hash_valid_i = 1'b1;
    step();
    bus.hash_valid_i = 1'b0;
    step();
    chk("t1 req held w/o ack", bus.fsm_start_req_o, 1'b1);
    bus.fsm_start_ack_i = 1'b1;
    step();
    chk("t1 req fell after ack", bus.fsm_start_req_o, 1'b0);
    step();
    chk("t1 no done while ack", bus.digest_valid_o, 1'b0);
    bus.fsm_start_ack_i = 1'b0;
    step();
    chk("t1 done after ack low", bus.digest_valid_o, 1'b1);
    chk("t1 digest", bus.digest_o, {256'b0, h1[511:256]});
    step(); step();
    chk("t1 digest_valid held", bus.digest_valid_o, 1'b1);
    bus.digest_ready_i = 1'b1;
    step();
    bus.digest_ready_i = 1'b0;
    chk("t1 back to idle", bus.busy_o, 1'b0);
    chk("t1 digest kept", bus.digest_o, {256'b0, h1[511:256]});

    // 3 words, last with 3 bytes: len 152, pad bit at 152
    start_msg(1'b1);
    put_word(64'hA7A6_A5A4_A3A2_A1A0, 1'b0, 4'd8);
    put_word(64'hB7B6_B5B4_B3B2_B1B0, 1'b0, 4'd8);
    put_word(64'hC7C6_C5C4_C3C2_C1C0, 1'b1, 4'd3);
    take_block("t2", {320'b0, 64'h0000_0000_01C2_C1C0, 64'hB7B6_B5B4_B3B2_B1B0,
                      64'hA7A6_A5A4_A3A2_A1A0}, 1'b1, 10'd152);
    finish("t2", h2, 1'b1);

    // 16 full words, stalled first block, full final block without pad bit
    start_msg(1'b1);
    for (int i = 0; i < 8; i++) put_word(wd(i), 1'b0, 4'd8);
    for (int i = 0; i < 8; i++) exp_m[64*i +: 64] = wd(i);
    bus.in_valid_i = 1'b1;
    bus.in_data_i  = wd(8);
    bus.in_bytes_i = 4'd8;
    for (int c = 0; c < 5; c++) begin
      chk("t3 stall mes_valid", bus.mes_valid_o, 1'b1);
      chk("t3 stall message", bus.message_o, exp_m);
      chk("t3 stall in_ready", bus.in_ready_o, 1'b0);
      step();
    end
    take_block("t3 blk1", exp_m, 1'b0, 10'd0);
    for (int i = 8; i < 15; i++) put_word(wd(i), 1'b0, 4'd8);
    put_word(wd(15), 1'b1, 4'd8);
    for (int i = 0; i < 8; i++) exp_m[64*i +: 64] = wd(i + 8);
    take_block("t3 blk2", exp_m, 1'b1, 10'd512);
    finish("t3", h1, 1'b1);

    // Reset after four words of a message
    start_msg(1'b1);
    for (int i = 0; i < 4; i++) put_word(wd(i + 20), 1'b0, 4'd8);
    rstn = 1'b0;
    step();
    chk_all_zero("midreset");
    rstn = 1'b1;
    step(); step();
    chk("t4 no req after reset", bus.fsm_start_req_o, 1'b0);
    bus.fsm_start_ack_i = 1'b1;
    bus.start_i = 1'b1;
    step();
    bus.start_i = 1'b0;
    chk("t4 start ignored while ack", bus.busy_o, 1'b0);
    chk("t4 req still low", bus.fsm_start_req_o, 1'b0);
    bus.fsm_start_ack_i = 1'b0;
    step();
    start_msg(1'b0);
    put_word(64'h1122_3344_5566_7788, 1'b0, 4'd8);
    put_word(64'hDEAD_BEEF_DEAD_BEEF, 1'b1, 4'd0);
    take_block("t4", {447'b0, 1'b1, 64'h1122_3344_5566_7788}, 1'b1, 10'd64);
    finish("t4", h2, 1'b0);

    // Oversized byte count on a single final word is clamped to 8
    start_msg(1'b1);
    put_word(64'h0F1E_2D3C_4B5A_6978, 1'b1, 4'd15);
    take_block("t5", {447'b0, 1'b1, 64'h0F1E_2D3C_4B5A_6978}, 1'b1, 10'd64);
    finish("t5", h1, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

`default_nettype wire
